seq_divider_16bit: RTL
======================

Name: seq_divider_16bit

Overview:
Multi-cycle 16-bit unsigned restoring divider with a start/done handshake. It is the inverse-direction companion to the registered 16-bit carry-lookahead adder wrapper: it divides by repeated trial subtraction, one quotient bit per clock. It sits beside the adder in the datapath and gives the block a divide operation without a combinational array.

Parameters:
WIDTH, 16, operand/quotient/remainder width; iteration count equals WIDTH.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, captured on accepted start
divisor  input  WIDTH  unsigned divisor, captured on accepted start
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  registered quotient, held until next accepted start completes
remainder  output  WIDTH  registered remainder, held likewise
div_by_zero  output  1  set with done when captured divisor == 0; held with results

Behaviour:
- Reset (rst=0, any time, including mid-RUN): FSM->IDLE immediately. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal operand/shift registers and counter = 0. The in-flight operation is discarded; no done is issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: on edge E0 with start=1, capture dividend/divisor.
  - If divisor != 0: clear partial remainder (WIDTH+1 bits), load the quotient shift register with the dividend, set counter=0, busy<=1, go to RUN.
  - If divisor == 0: go straight to DONE with quotient<={WIDTH{1}}, remainder<=dividend, div_by_zero<=1, done<=1. busy stays 0.
  - start=0: remain in IDLE.
- RUN, one iteration per edge:
  - Shift {rem, q} left by 1.
  - Trial difference: rem_shifted + ~{0,divisor} + 1, computed at WIDTH+1 bits (carry-in 1, adder convention).
  - If the MSB of the difference is 0 (no borrow): rem<=difference and q[0]<=1. Otherwise rem is kept and q[0]<=0.
  - Counter increments each edge. The iteration at count==WIDTH-1 is the last: on that edge write quotient/remainder outputs, div_by_zero<=0, done<=1, busy<=0, go to DONE.
- Latency: start accepted at E0 -> done high in the cycle after edge E0+WIDTH (E16 at default). Divide-by-zero -> done after E0+1... i.e. in the cycle after E0.
- DONE: lasts one cycle. done<=0 on the next edge, go to IDLE. start is ignored in DONE; the earliest next accept is the edge after DONE.
- start asserted during RUN or DONE is ignored and is not queued. dividend/divisor changes after capture have no effect.
- Result outputs change only on the edge that asserts done, or on reset.
- Width rules: all arithmetic is unsigned. Partial remainder is WIDTH+1 bits internally, and the output remainder is its low WIDTH bits. Invariant: quotient*divisor + remainder == dividend and remainder < divisor when divisor != 0.
- Simultaneous: reset overrides everything. done and busy are never both 1.

Test Plan:
- Reset then dividend=100, divisor=7, start pulse at E0 -> busy=1 for 16 cycles; done pulses for exactly 1 cycle after E16; quotient=14, remainder=2, div_by_zero=0.
- dividend=16'hFFFF, divisor=16'h0001 -> quotient=16'hFFFF, remainder=0. Back-to-back: dividend=16'hFFFF, divisor=16'hFFFF -> quotient=1, remainder=0, started the cycle after DONE.
- dividend=5, divisor=9 -> quotient=0, remainder=5. dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=16'h1234, divisor=0 -> done in the cycle after E0, busy never high, quotient=16'hFFFF, remainder=16'h1234, div_by_zero=1. A following 50/5 operation -> quotient=10, remainder=0, div_by_zero cleared.
- Start 1000/3, then pulse start with 9/9 at E5 (during RUN) -> second request ignored; result quotient=333, remainder=1 at E16; outputs stable afterward.
- Start 1000/3, drive rst=0 asynchronously mid-cycle at E8+0.3 ns -> all outputs 0 immediately with no done. After release, 200/8 -> quotient=25, remainder=0 after 16 edges.
- Random sweep of 10k unsigned pairs (divisor != 0) checked against the invariant and a reference model.

Source files
------------

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes in one cycle with an all-ones quotient and the dividend as remainder.
module seq_divider_16bit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // The stored remainder is always < divisor, so WIDTH bits suffice; the shifted
    // partial remainder and the trial difference need the extra bit.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        rem_shift = {rem_q, q_q[WIDTH-1]};
        diff      = rem_shift + ~{1'b0, dvs_q} + {{WIDTH{1'b0}}, 1'b1};
        rem_next  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next    = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    q_d   = dividend;
                    if (divisor != '0) begin
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                rem_d = rem_next;
                q_d   = q_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quotient_d  = q_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
